// File: rtl/step_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : step_monitor_pkg
// Brief    : Shared state encoding and field widths for the step monitor.
// Revision : 1.0 - initial release
// ============================================================================
package step_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int STEP_W     = 14;
    localparam int RATE_W     = 8;
    localparam int SEC_W      = 9;
    localparam int DEF_CLK_HZ = 100_000_000;

endpackage
`default_nettype wire

// File: rtl/step_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : step_monitor_if
// Brief    : Pulse inputs and measurement outputs of the step monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface step_monitor_if;
    import step_monitor_pkg::*;

    logic              pulse;
    logic              pulsestart;
    logic [STEP_W-1:0] step_count;
    logic [RATE_W-1:0] steps_per_sec;
    logic [SEC_W-1:0]  seconds;
    logic [SEC_W-1:0]  active_secs;
    logic              sec_tick;
    logic              overflow;
    logic [RATE_W-1:0] max_rate;

    modport master (
        output pulse, pulsestart,
        input  step_count, steps_per_sec, seconds, active_secs,
        input  sec_tick, overflow, max_rate
    );

    modport slave (
        input  pulse, pulsestart,
        output step_count, steps_per_sec, seconds, active_secs,
        output sec_tick, overflow, max_rate
    );

endinterface
`default_nettype wire

// File: rtl/sec_timer.sv
`default_nettype none
// ============================================================================
// Module   : sec_timer
// Brief    : Free-running 0..CLK_HZ-1 window timer; tick on the terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module sec_timer #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int            CW     = $clog2(CLK_HZ);
    localparam logic [CW-1:0] c_LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == c_LAST);
    assign tick   = en && w_last;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/step_monitor.sv
`default_nettype none
// ============================================================================
// Module   : step_monitor
// Brief    : Counts pulse steps, per-second rate and active seconds per session.
//            Optional macro STEP_MONITOR_MAXRATE_EN enables peak-rate tracking.
// Revision : 1.0 - initial release
// ============================================================================
module step_monitor
    import step_monitor_pkg::*;
#(
    parameter int CLK_HZ        = DEF_CLK_HZ,
    parameter int SAT_STEPS     = 9999,
    parameter int ACTIVE_THRESH = 32
) (
    input  logic          clk,
    input  logic          reset,
    step_monitor_if.slave bus
);
    localparam logic [STEP_W-1:0] c_SAT_STEPS = STEP_W'(SAT_STEPS);
    // Thresholds above the 8-bit window range can never be met.
    localparam logic [RATE_W:0]   c_THRESH    = (ACTIVE_THRESH > 255) ? 9'h100
                                                : (RATE_W+1)'(ACTIVE_THRESH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_entry;
    logic              w_run;
    logic              w_edge;
    logic              w_tick;
    logic              w_active;
    logic              r_pulse_d;
    logic [STEP_W-1:0] r_step;
    logic [RATE_W-1:0] r_win;
    logic [RATE_W-1:0] w_win_nxt;
    logic [RATE_W-1:0] r_sps;
    logic [SEC_W-1:0]  r_sec;
    logic [SEC_W-1:0]  r_act;
    logic              r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_entry     = 1'b0;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (bus.pulsestart) begin
                    w_state_nxt = ST_RUN;
                    w_entry     = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.pulsestart) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counting only happens on RUN cycles that are not leaving RUN.
    assign w_run     = (r_state == ST_RUN) && bus.pulsestart && !reset;
    assign w_edge    = bus.pulse && !r_pulse_d;
    assign w_win_nxt = (w_edge && (r_win != '1)) ? r_win + RATE_W'(1) : r_win;
    assign w_active  = ({1'b0, w_win_nxt} >= c_THRESH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse_d <= 1'b0;
        end else begin
            r_pulse_d <= bus.pulse;
        end
    end

    sec_timer #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_timer (
        .clk   (clk),
        .reset (reset),
        .clear (w_entry),
        .en    (w_run),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset || w_entry) begin
            r_step <= '0;
            r_win  <= '0;
            r_sps  <= '0;
            r_sec  <= '0;
            r_act  <= '0;
            r_ovf  <= 1'b0;
        end else if (w_run) begin
            if (w_edge) begin
                if (r_step == c_SAT_STEPS) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_step <= r_step + STEP_W'(1);
                end
            end
            if (w_tick) begin
                r_sps <= w_win_nxt;
                r_win <= '0;
                if (r_sec != '1) begin
                    r_sec <= r_sec + SEC_W'(1);
                end
                if (w_active && (r_act != '1)) begin
                    r_act <= r_act + SEC_W'(1);
                end
            end else begin
                r_win <= w_win_nxt;
            end
        end
    end

`ifdef STEP_MONITOR_MAXRATE_EN
    logic [RATE_W-1:0] r_max;

    always_ff @(posedge clk) begin
        if (reset || w_entry) begin
            r_max <= '0;
        end else if (w_run && w_tick && (w_win_nxt > r_max)) begin
            r_max <= w_win_nxt;
        end
    end

    assign bus.max_rate = r_max;
`else
    assign bus.max_rate = '0;
`endif

    assign bus.step_count    = r_step;
    assign bus.steps_per_sec = r_sps;
    assign bus.seconds       = r_sec;
    assign bus.active_secs   = r_act;
    assign bus.sec_tick      = w_tick;
    assign bus.overflow      = r_ovf;

endmodule
`default_nettype wire
